// File: rtl/axis_pkg.sv
// axis_pkg: shared types and constants for the AXI4-Stream packetizer.
//   AXIS_DATA_W : default stream data width
//   DROP_CNT_W  : width of the dropped-beat counter
//   state_t     : packetizer FSM state (IDLE, ACTIVE)
//   beat_t      : one buffered beat, data plus its precomputed last flag
package axis_pkg;
    localparam int AXIS_DATA_W = 32;
    localparam int DROP_CNT_W  = 32;
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic [AXIS_DATA_W-1:0] data;
        logic                   last;
    } beat_t;
endpackage

// File: rtl/axis_packetizer_if.sv
// axis_packetizer_if: AXI4-Stream bundle (tdata, tvalid, tready, tlast).
//   master : drives tdata/tvalid/tlast, receives tready
//   slave  : receives tdata/tvalid, drives tready (the input stream carries no tlast)
interface axis_packetizer_if #(parameter int DATA_W = 32);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    modport master(output tdata, tvalid, tlast, input tready);
    modport slave(input tdata, tvalid, output tready);
endinterface

// File: rtl/axis_skid_buffer.sv
// axis_skid_buffer: two-entry register slice (output register + skid register).
//   aclk, aresetn    : clock, asynchronous active-low reset
//   s_valid/s_beat   : upstream beat, s_ready is registered "skid empty"
//   m_valid/m_beat   : downstream beat from the output register, m_ready backpressure
module axis_skid_buffer #(
    parameter type beat_t = axis_pkg::beat_t
) (
    input  logic  aclk,
    input  logic  aresetn,
    input  logic  s_valid,
    input  beat_t s_beat,
    output logic  s_ready,
    output logic  m_valid,
    output beat_t m_beat,
    input  logic  m_ready
);
    logic  out_valid_q, out_valid_d, skid_valid_q, skid_valid_d, ready_q, ready_d;
    beat_t out_q, out_d, skid_q, skid_d;
    logic  acc, out_free;

    // ready_q mirrors !skid_valid_q, so an accepted beat always finds the skid empty
    always_comb begin
        acc          = s_valid & ready_q;
        out_free     = !out_valid_q | m_ready;
        out_valid_d  = out_valid_q;
        out_d        = out_q;
        skid_valid_d = skid_valid_q;
        skid_d       = skid_q;
        if (skid_valid_q && out_free) begin
            out_d        = skid_q;
            out_valid_d  = 1'b1;
            skid_valid_d = 1'b0;
        end else if (acc && out_free) begin
            out_d       = s_beat;
            out_valid_d = 1'b1;
        end else if (acc) begin
            skid_d       = s_beat;
            skid_valid_d = 1'b1;
        end else if (m_ready) begin
            out_valid_d = 1'b0;
        end
        ready_d = !skid_valid_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b0;
            out_q        <= '0;
            skid_q       <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            out_q        <= out_d;
            skid_q       <= skid_d;
        end
    end

    assign s_ready = ready_q;
    assign m_valid = out_valid_q;
    assign m_beat  = out_q;
endmodule

// File: rtl/axis_packetizer.sv
// axis_packetizer: tags m_axis.tlast on every (cfg_data+1)-th beat of a tlast-less stream.
//   aclk, aresetn : clock, asynchronous active-low reset
//   cfg_data      : packet length minus one, sampled on the first beat of each packet
//   s_axis        : input stream (slave), tready is registered
//   m_axis        : output stream (master) with tlast
//   sts_drop      : beats offered while tready was low, saturating
//                   (present only when AXIS_PACKETIZER_DROP_CNT_EN is defined)
module axis_packetizer
    import axis_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int CNTR_WIDTH       = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [CNTR_WIDTH-1:0] cfg_data,
    axis_packetizer_if.slave      s_axis,
    axis_packetizer_if.master     m_axis
`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0] sts_drop
`endif
);
    typedef struct packed {
        logic [AXIS_TDATA_WIDTH-1:0] data;
        logic                        last;
    } pbeat_t;

    state_t                state_q, state_d;
    logic [CNTR_WIDTH-1:0] len_q, len_d, cnt_q, cnt_d, cnt_nxt;
    logic                  acc, last;
    pbeat_t                in_beat, out_beat;

    // cnt_q holds the index of the previous beat in the packet; the beat whose
    // index equals len_q is last, so cnt never exceeds len_q and cannot overflow
    always_comb begin
        acc     = s_axis.tvalid & s_axis.tready;
        cnt_nxt = cnt_q + CNTR_WIDTH'(1);
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        last    = 1'b0;
        if (acc && state_q == IDLE) begin
            len_d   = cfg_data;
            cnt_d   = '0;
            last    = cfg_data == '0;
            state_d = last ? IDLE : ACTIVE;
        end else if (acc) begin
            last    = cnt_nxt == len_q;
            cnt_d   = last ? '0 : cnt_nxt;
            state_d = last ? IDLE : ACTIVE;
        end
        in_beat = '{data: s_axis.tdata, last: last};
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    axis_skid_buffer #(.beat_t(pbeat_t)) u_skid (
        .aclk    (aclk),
        .aresetn (aresetn),
        .s_valid (s_axis.tvalid),
        .s_beat  (in_beat),
        .s_ready (s_axis.tready),
        .m_valid (m_axis.tvalid),
        .m_beat  (out_beat),
        .m_ready (m_axis.tready)
    );

    assign m_axis.tdata = out_beat.data;
    assign m_axis.tlast = out_beat.last;

`ifdef AXIS_PACKETIZER_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    always_comb begin
        drop_d = (s_axis.tvalid && !s_axis.tready && drop_q != '1) ? drop_q + DROP_CNT_W'(1) : drop_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) drop_q <= '0;
        else          drop_q <= drop_d;
    end

    assign sts_drop = drop_q;
`endif
endmodule
